// File: rtl/pc_sel_ctrl.sv
// Fetch-stage next-PC controller: owns the PC, drives the next-PC mux select and
// buffers a redirect that arrives while fetch is stalled. Optional: PC_ALIGN_CHECK_EN.
module pc_sel_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        br_taken,
   input  logic        is_j,
   input  logic        is_jr,
   input  logic [31:0] npc_in,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [1:0]  pc_op,
`ifdef PC_ALIGN_CHECK_EN
   output logic        adel,
`endif
   output logic        redirect_pend
);

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      PEND = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] tgt_q, tgt_d;
   logic [1:0]  op_q, op_d;
   logic [1:0]  req_op;
   logic [1:0]  op_sel;
   logic        load;
   logic [31:0] load_val;
   logic        misaligned;

   // Fixed priority: jr over j over taken branch.
   always_comb begin
      if (is_jr)         req_op = 2'b11;
      else if (is_j)     req_op = 2'b10;
      else if (br_taken) req_op = 2'b01;
      else               req_op = 2'b00;
   end

   always_comb begin
      state_d    = state_q;
      tgt_d      = tgt_q;
      op_d       = op_q;
      op_sel     = req_op;
      load       = 1'b0;
      load_val   = npc_in;
      misaligned = 1'b0;
      pc_d       = pc_q;
      case (state_q)
         RUN: begin
            if (!stall) begin
               load = 1'b1;
            end else if (req_op != 2'b00) begin
               tgt_d   = npc_in;
               op_d    = req_op;
               state_d = PEND;
            end
         end
         PEND: begin
            op_sel = op_q;
            if (!stall) begin
               load     = 1'b1;
               load_val = tgt_q;
               state_d  = RUN;
            end
         end
         default: state_d = RUN;
      endcase
      if (load) begin
`ifdef PC_ALIGN_CHECK_EN
         misaligned = (load_val[1:0] != 2'b00);
         pc_d       = misaligned ? EXC_VEC : load_val;
`else
         pc_d       = load_val;
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         tgt_q   <= '0;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         op_q    <= op_d;
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) adel <= 1'b0;
      else       adel <= misaligned;
   end
`endif

   assign pc            = pc_q;
   assign pc_plus4      = pc_q + 32'd4;
   // The select must read 00 for the whole reset assertion, not just after the edge.
   assign pc_op         = reset ? 2'b00 : op_sel;
   assign redirect_pend = (state_q == PEND);

endmodule
